seg7_display_arbiter: RTL



---
 rtl/seg7_display_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg7_display_arbiter.sv
// Round-robin owner arbiter for the shared 4-digit seven-segment display, with a minimum hold time per owner.
// Optional urgent requester 0 preemption is compiled in with `define SEG7_ARB_PREEMPT_EN.
module seg7_display_arbiter #(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_value,
  output logic [NREQ-1:0]      gnt,
  output logic [15:0]          disp_value,
  output logic                 disp_blank,
  output logic                 switch_pulse
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] rrPtr_q;
  logic [CNT_W-1:0] holdCnt_q;
  logic [NREQ-1:0]  gnt_q;
  logic [15:0]      dispValue_q;
  logic             dispBlank_q;
  logic             switchPulse_q;

  logic [15:0]      srcValue [NREQ];
  logic [NREQ-1:0]  ownerMask;
  logic             expired, ownerReq, otherReq, preemptHit;
  logic [CNT_W-1:0] holdNext;
  logic [IDX_W-1:0] idlePick, lingerPick, rotatePick;
  logic             doGrant_d, doRotate_d, doIdle_d, toLinger_d;
  logic [IDX_W-1:0] grantIdx_d;

  function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] idx);
    int j;
    j = int'(idx) + 1;
    if (j >= NREQ) j = 0;
    return IDX_W'(j);
  endfunction

  // Walk offsets from high to low so the nearest set bit after 'start' wins.
  function automatic logic [IDX_W-1:0] pickFrom(input logic [NREQ-1:0] r,
                                                input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] sel;
    int j;
    sel = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NREQ) j = j - NREQ;
      if (r[IDX_W'(j)]) sel = IDX_W'(j);
    end
    return sel;
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_src
    assign srcValue[i] = req_value[16*i +: 16];
  end

  assign ownerMask  = NREQ'(1) << owner_q;
  assign expired    = (holdCnt_q == HOLD_LAST);
  assign ownerReq   = |(req & ownerMask);
  assign otherReq   = |(req & ~ownerMask);
  assign holdNext   = expired ? holdCnt_q : holdCnt_q + CNT_W'(1);
  assign idlePick   = pickFrom(req, rrPtr_q);
  assign lingerPick = pickFrom(req, wrapInc(owner_q));
  assign rotatePick = pickFrom(req & ~ownerMask, wrapInc(owner_q));

`ifdef SEG7_ARB_PREEMPT_EN
  assign preemptHit = (state_q != IDLE) && (owner_q != '0) && req[0];
`else
  assign preemptHit = 1'b0;
`endif

  always_comb begin
    doGrant_d  = 1'b0;
    doRotate_d = 1'b0;
    doIdle_d   = 1'b0;
    toLinger_d = 1'b0;
    grantIdx_d = idlePick;
    case (state_q)
      IDLE: doGrant_d = |req;
      SHOW: begin
        if (preemptHit) begin
          doGrant_d  = 1'b1;
          grantIdx_d = '0;
        end else if (!ownerReq && !expired) begin
          toLinger_d = 1'b1;
        end else if (expired && otherReq) begin
          doGrant_d  = 1'b1;
          doRotate_d = 1'b1;
          grantIdx_d = rotatePick;
        end else if (expired && !ownerReq) begin
          doIdle_d = 1'b1;
        end
      end
      LINGER: begin
        if (preemptHit) begin
          doGrant_d  = 1'b1;
          grantIdx_d = '0;
        end else if (expired) begin
          doGrant_d  = |req;
          doIdle_d   = ~(|req);
          grantIdx_d = lingerPick;
        end
      end
      default: doIdle_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rrPtr_q       <= '0;
      holdCnt_q     <= '0;
      gnt_q         <= '0;
      dispValue_q   <= '0;
      dispBlank_q   <= 1'b1;
      switchPulse_q <= 1'b0;
    end else begin
      switchPulse_q <= doGrant_d;
      if (doGrant_d) begin
        state_q     <= SHOW;
        owner_q     <= grantIdx_d;
        gnt_q       <= NREQ'(1) << grantIdx_d;
        dispValue_q <= srcValue[grantIdx_d];
        dispBlank_q <= 1'b0;
        holdCnt_q   <= '0;
        if (doRotate_d) rrPtr_q <= wrapInc(grantIdx_d);
      end else if (doIdle_d) begin
        state_q     <= IDLE;
        gnt_q       <= '0;
        dispValue_q <= '0;
        dispBlank_q <= 1'b1;
        holdCnt_q   <= '0;
        rrPtr_q     <= wrapInc(owner_q);
      end else if (toLinger_d) begin
        // The last captured value stays on screen while the hold time runs out.
        state_q   <= LINGER;
        gnt_q     <= '0;
        holdCnt_q <= holdNext;
      end else if (state_q == SHOW) begin
        dispValue_q <= srcValue[owner_q];
        holdCnt_q   <= holdNext;
      end else if (state_q == LINGER) begin
        holdCnt_q <= holdNext;
      end
    end
  end

  assign gnt          = gnt_q;
  assign disp_value   = dispValue_q;
  assign disp_blank   = dispBlank_q;
  assign switch_pulse = switchPulse_q;

endmodule
